// File: rtl/offset_mix_sequencer.sv
// offset_mix_sequencer
// Sums the throttle, pitch, roll and yaw offset-generator bytes for each of the
// four motors. It uses one shared 11-bit signed accumulator and processes one
// byte per cycle. Each motor result is clamped to [MIN_DUTY, MAX_DUTY] and held
// in a shadow register. All four duties are published together when the mix
// completes.
// Optional feature macro: SLEW_LIMIT_EN. When it is defined, each published duty
// may move at most MAX_STEP away from the value currently on that motor output.
module offset_mix_sequencer #(
  parameter int CENTER   = 20,
  parameter int MIN_DUTY = 0,
  parameter int MAX_DUTY = 100,
  parameter int RST_DUTY = 0
`ifdef SLEW_LIMIT_EN
  ,
  parameter int MAX_STEP = 5
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] thr_offsets,
  input  logic [31:0] pitch_offsets,
  input  logic [31:0] roll_offsets,
  input  logic [31:0] yaw_offsets,
  output logic        busy,
  output logic        done,
  output logic [7:0]  motor_1_duty,
  output logic [7:0]  motor_2_duty,
  output logic [7:0]  motor_3_duty,
  output logic [7:0]  motor_4_duty
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CLAMP,
    DONE
  } state_e;

  // Each motor sums three neutral-centred generators, so the three
  // neutral offsets are removed up front.
  localparam logic signed [10:0] ACC_INIT = 11'(-3 * CENTER);
  localparam logic signed [10:0] MIN_S    = 11'(MIN_DUTY);
  localparam logic signed [10:0] MAX_S    = 11'(MAX_DUTY);
  localparam logic [7:0]         RST_VAL  = 8'(RST_DUTY);

  state_e             state_q, state_d;
  logic signed [10:0] acc_q, acc_d;
  logic [1:0]         motorIdx_q, motorIdx_d;
  logic [1:0]         srcIdx_q, srcIdx_d;
  logic [127:0]       snap_q, snap_d;
  logic [7:0]         shadow_q [4];
  logic [7:0]         shadow_d [4];
  logic [7:0]         duty_q [4];
  logic [7:0]         duty_d [4];

  logic [7:0]         snapByte;
  logic [7:0]         clampRes;
  logic [7:0]         mixRes;

  // The snapshot is packed as {yaw, roll, pitch, thr}, with motor 1 in the
  // low byte of each word. The bit offset is therefore {source, motor, 3'b0}.
  assign snapByte = snap_q[{srcIdx_q, motorIdx_q, 3'b000} +: 8];

  // Clamp the finished signed sum into the allowed duty range.
  always_comb begin
    clampRes = acc_q[7:0];
    if (acc_q < MIN_S) begin
      clampRes = MIN_S[7:0];
    end else if (acc_q > MAX_S) begin
      clampRes = MAX_S[7:0];
    end
  end

`ifdef SLEW_LIMIT_EN
  logic signed [9:0] prev10, res10, hi10, lo10;

  // Limit the step against the duty currently driven on this motor. The math
  // is 10-bit signed so that prev +/- MAX_STEP cannot wrap.
  always_comb begin
    prev10 = $signed({2'b00, duty_q[motorIdx_q]});
    res10  = $signed({2'b00, clampRes});
    hi10   = prev10 + $signed(10'(MAX_STEP));
    lo10   = prev10 - $signed(10'(MAX_STEP));
    mixRes = clampRes;
    if (res10 > hi10) begin
      mixRes = hi10[7:0];
    end else if (res10 < lo10) begin
      mixRes = lo10[7:0];
    end
  end
`else
  assign mixRes = clampRes;
`endif

  // Sequencer next-state logic: snapshot, accumulate four sources, clamp,
  // and repeat for four motors. The edge that enters DONE then publishes
  // all duties at once.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    motorIdx_d = motorIdx_q;
    srcIdx_d   = srcIdx_q;
    snap_d     = snap_q;
    shadow_d   = shadow_q;
    duty_d     = duty_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = {yaw_offsets, roll_offsets, pitch_offsets, thr_offsets};
          acc_d      = ACC_INIT;
          motorIdx_d = 2'd0;
          srcIdx_d   = 2'd0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        acc_d    = acc_q + $signed({3'b000, snapByte});
        srcIdx_d = srcIdx_q + 2'd1;
        if (srcIdx_q == 2'd3) begin
          state_d = CLAMP;
        end
      end
      CLAMP: begin
        shadow_d[motorIdx_q] = mixRes;
        acc_d                = ACC_INIT;
        if (motorIdx_q == 2'd3) begin
          // The motor 4 result is still being written into the shadow
          // register on this edge, so it is forwarded straight to the output.
          duty_d[0] = shadow_q[0];
          duty_d[1] = shadow_q[1];
          duty_d[2] = shadow_q[2];
          duty_d[3] = mixRes;
          state_d   = DONE;
        end else begin
          motorIdx_d = motorIdx_q + 2'd1;
          srcIdx_d   = 2'd0;
          state_d    = ACCUM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any mix in flight and drives
  // the motors off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      motorIdx_q <= 2'd0;
      srcIdx_q   <= 2'd0;
      snap_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= RST_VAL;
        duty_q[i]   <= RST_VAL;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      motorIdx_q <= motorIdx_d;
      srcIdx_q   <= srcIdx_d;
      snap_q     <= snap_d;
      shadow_q   <= shadow_d;
      duty_q     <= duty_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign motor_1_duty = duty_q[0];
  assign motor_2_duty = duty_q[1];
  assign motor_3_duty = duty_q[2];
  assign motor_4_duty = duty_q[3];

endmodule

// File: tb/tb_offset_mix_sequencer.sv
// Directed testbench for offset_mix_sequencer.
// Cycle k is the period after clock edge k-1, where edge 0 samples start.
// A start driven in cycle k is sampled at edge k. All driving and sampling
// happens on the falling edge.
module tb_offset_mix_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] thrOffsets;
  logic [31:0] pitchOffsets;
  logic [31:0] rollOffsets;
  logic [31:0] yawOffsets;
  logic        busy;
  logic        done;
  logic [7:0]  motor1Duty;
  logic [7:0]  motor2Duty;
  logic [7:0]  motor3Duty;
  logic [7:0]  motor4Duty;

  int testsRun    = 0;
  int testsFailed = 0;

  // Expected motor duties: motor n is at index n-1.
  logic [7:0] expDuty [4];

  // Window expectations for one undisturbed mix: busy in cycles 1-21 and
  // done only in cycle 21.
  localparam logic [31:0] BUSY_ONE = 32'h003F_FFFE;
  localparam logic [31:0] DONE_ONE = 32'h0020_0000;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  offset_mix_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .thr_offsets   (thrOffsets),
    .pitch_offsets (pitchOffsets),
    .roll_offsets  (rollOffsets),
    .yaw_offsets   (yawOffsets),
    .busy          (busy),
    .done          (done),
    .motor_1_duty  (motor1Duty),
    .motor_2_duty  (motor2Duty),
    .motor_3_duty  (motor3Duty),
    .motor_4_duty  (motor4Duty)
  );

  // Advance the expected duties toward hand-computed per-motor targets.
  // Targets are packed {m4, m3, m2, m1}. The slew build moves at most 5 per mix.
  task automatic updateModel(input logic [31:0] targets);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] t;
      t = targets[i*8 +: 8];
`ifdef SLEW_LIMIT_EN
      if (int'(t) > int'(expDuty[i]) + 5) begin
        expDuty[i] = expDuty[i] + 8'd5;
      end else if (int'(t) < int'(expDuty[i]) - 5) begin
        expDuty[i] = expDuty[i] - 8'd5;
      end else begin
        expDuty[i] = t;
      end
`else
      expDuty[i] = t;
`endif
    end
  endtask

  // Pack the expected duties as {m4, m3, m2, m1}.
  function automatic logic [31:0] expPacked();
    return {expDuty[3], expDuty[2], expDuty[1], expDuty[0]};
  endfunction

  // Launch one mix from IDLE and record busy/done for cycles 1..nCycles.
  // startMask bit k drives start during cycle k. The duties are captured
  // whenever done is observed.
  task automatic runMix(input logic [31:0] startMask, input int nCycles, input bit scramble,
                        output logic [31:0] busyObs, output logic [31:0] doneObs,
                        output logic [31:0] dutyObs);
    busyObs = '0;
    doneObs = '0;
    dutyObs = '0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= nCycles; c++) begin
      busyObs[c] = busy;
      doneObs[c] = done;
      if (done === 1'b1) dutyObs = {motor4Duty, motor3Duty, motor2Duty, motor1Duty};
      if (scramble && c == 2) begin
        thrOffsets   = $urandom;
        pitchOffsets = $urandom;
        rollOffsets  = $urandom;
        yawOffsets   = $urandom;
      end
      start = startMask[c];
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Reset values before and just after reset release.
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    thrOffsets = '0; pitchOffsets = '0; rollOffsets = '0; yawOffsets = '0;
    for (int i = 0; i < 4; i++) expDuty[i] = 8'd0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    testsRun++;
    if ({motor4Duty, motor3Duty, motor2Duty, motor1Duty} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_duty: got %h expected 00000000",
               {motor4Duty, motor3Duty, motor2Duty, motor1Duty});
    end
    rst_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  // Neutral mix: 40 + 3*20 - 60 = 40 on every motor. The inputs are
  // scrambled mid-mix to show that the snapshot is used.
  task automatic test_neutral();
    logic [31:0] b, d, duty;
    thrOffsets = 32'h2828_2828;
    pitchOffsets = 32'h1414_1414; rollOffsets = 32'h1414_1414; yawOffsets = 32'h1414_1414;
    runMix('0, 22, 1'b1, b, d, duty);
    updateModel(32'h2828_2828);
    testsRun++;
    if (b !== BUSY_ONE) begin
      testsFailed++;
      $display("[TB] FAIL neutral_busy: got %h expected %h", b, BUSY_ONE);
    end
    testsRun++;
    if (d !== DONE_ONE) begin
      testsFailed++;
      $display("[TB] FAIL neutral_done: got %h expected %h", d, DONE_ONE);
    end
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL neutral_duty: got %h expected %h", duty, expPacked());
    end
    testsRun++;
    if ({motor4Duty, motor3Duty, motor2Duty, motor1Duty} !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL neutral_hold: got %h expected %h",
               {motor4Duty, motor3Duty, motor2Duty, motor1Duty}, expPacked());
    end
  endtask

  // High clamp: 255 + 90 - 60 = 285, which clamps to 100 on every motor.
  task automatic test_high_clamp();
    logic [31:0] b, d, duty;
    thrOffsets = 32'hFFFF_FFFF;
    pitchOffsets = 32'h1E1E_1E1E; rollOffsets = 32'h1E1E_1E1E; yawOffsets = 32'h1E1E_1E1E;
    runMix('0, 22, 1'b0, b, d, duty);
    updateModel(32'h6464_6464);
    testsRun++;
    if (d !== DONE_ONE) begin
      testsFailed++;
      $display("[TB] FAIL high_done: got %h expected %h", d, DONE_ONE);
    end
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL high_duty: got %h expected %h", duty, expPacked());
    end
  endtask

  // Low clamp with distinct motors: m1 -30 -> 0, m2 0, m3 50, m4 30.
  task automatic test_low_clamp();
    logic [31:0] b, d, duty;
    thrOffsets = 32'h0032_0000;
    pitchOffsets = 32'h1E14_140A; rollOffsets = 32'h1E14_140A; yawOffsets = 32'h1E14_140A;
    runMix('0, 22, 1'b0, b, d, duty);
    updateModel(32'h1E32_0000);
    testsRun++;
    if (b !== BUSY_ONE) begin
      testsFailed++;
      $display("[TB] FAIL low_busy: got %h expected %h", b, BUSY_ONE);
    end
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL low_duty: got %h expected %h", duty, expPacked());
    end
  endtask

  // Starts in cycles 5 and 21 are ignored. A start in cycle 22 launches a
  // second mix, whose done lands in cycle 43.
  task automatic test_back_to_back();
    logic [31:0] b, d, duty;
    int doneAt;
    runMix(32'h0060_0020, 24, 1'b0, b, d, duty);
    updateModel(32'h1E32_0000);
    testsRun++;
    if (b !== 32'h01BF_FFFE) begin
      testsFailed++;
      $display("[TB] FAIL b2b_busy: got %h expected %h", b, 32'h01BF_FFFE);
    end
    testsRun++;
    if (d !== DONE_ONE) begin
      testsFailed++;
      $display("[TB] FAIL b2b_done: got %h expected %h", d, DONE_ONE);
    end
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL b2b_duty1: got %h expected %h", duty, expPacked());
    end
    doneAt = 0;
    for (int c = 25; c < 65 && doneAt == 0; c++) begin
      if (done === 1'b1) begin
        doneAt = c;
        duty = {motor4Duty, motor3Duty, motor2Duty, motor1Duty};
      end
      @(negedge clk);
    end
    updateModel(32'h1E32_0000);
    testsRun++;
    if (doneAt != 43) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_done_cycle: got %0d expected 43", doneAt);
    end
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL b2b_duty2: got %h expected %h", duty, expPacked());
    end
  endtask

  // Reset in cycle 10 aborts the mix. No done pulse follows, and the duties
  // stay off.
  task automatic test_reset_mid_mix();
    bit doneSeen;
    thrOffsets = 32'h5050_5050;
    pitchOffsets = 32'h1414_1414; rollOffsets = 32'h1414_1414; yawOffsets = 32'h1414_1414;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expDuty[i] = 8'd0;
    doneSeen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done !== 1'b0) doneSeen = 1'b1;
      @(negedge clk);
    end
    testsRun++;
    if (doneSeen !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_done: got %b expected 0", doneSeen);
    end
    testsRun++;
    if ({motor4Duty, motor3Duty, motor2Duty, motor1Duty} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_duty: got %h expected 00000000",
               {motor4Duty, motor3Duty, motor2Duty, motor1Duty});
    end
  endtask

  // Settle at 40, then target 100 and target 0. The slew build gives 45 and
  // then 40. The default build gives 100 and then 0.
  task automatic test_slew();
    logic [31:0] b, d, duty;
    thrOffsets = 32'h2828_2828;
    pitchOffsets = 32'h1414_1414; rollOffsets = 32'h1414_1414; yawOffsets = 32'h1414_1414;
    for (int k = 0; k < 8; k++) begin
      runMix('0, 22, 1'b0, b, d, duty);
      updateModel(32'h2828_2828);
    end
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL slew_settle: got %h expected %h", duty, expPacked());
    end
    thrOffsets = 32'hFFFF_FFFF;
    pitchOffsets = 32'h1E1E_1E1E; rollOffsets = 32'h1E1E_1E1E; yawOffsets = 32'h1E1E_1E1E;
    runMix('0, 22, 1'b0, b, d, duty);
    updateModel(32'h6464_6464);
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL slew_up: got %h expected %h", duty, expPacked());
    end
    thrOffsets = 32'h0000_0000;
    pitchOffsets = 32'h1414_1414; rollOffsets = 32'h1414_1414; yawOffsets = 32'h1414_1414;
    runMix('0, 22, 1'b0, b, d, duty);
    updateModel(32'h0000_0000);
    testsRun++;
    if (duty !== expPacked()) begin
      testsFailed++;
      $display("[TB] FAIL slew_down: got %h expected %h", duty, expPacked());
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_neutral();
    test_high_clamp();
    test_low_clamp();
    test_back_to_back();
    test_reset_mid_mix();
    test_slew();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
